// File: rtl/fadd_ctrl_pkg.sv
// Shared types and defaults for the fadd requester-side controller.
package fadd_ctrl_pkg;

  localparam int unsigned FADD_LAT_DEF = 2;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam int unsigned TAG_W_DEF    = 5;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  // IEEE-754 single precision view of a 32-bit word.
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  // Result flags, bit order [2]=in_special, [1]=zero, [0]=overflow.
  typedef struct packed {
    logic in_special;
    logic zero;
    logic overflow;
  } exc_flags_t;

  function automatic logic is_special(input fp32_t x);
    return x.exp == EXP_MAX;
  endfunction

  function automatic exc_flags_t exc_flags(input fp32_t y, input logic in_special);
    exc_flags_t f;
    f.overflow   = (y.exp == EXP_MAX);
    f.zero       = (y.exp == 8'h00) && (y.mant == 23'h0);
    f.in_special = in_special;
    return f;
  endfunction

endpackage

// File: rtl/fadd_ctrl_fifo.sv
// Synchronous circular FIFO with occupancy count; pop frees an entry before a
// same-cycle push, so push+pop on a full FIFO is legal.
module fadd_ctrl_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly at DEPTH so non-power-of-two depths also work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Next-state: guarded push/pop, pointer advance and occupancy update.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CntW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; contents cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fadd_ctrl.sv
// Requester-side controller for a fixed-latency, handshake-free fadd pipeline.
// Issues operands, tracks in-flight ops with a valid/tag shift register and
// returns results in order through a credit-protected response FIFO.
// Optional macro FADD_CTRL_EXC_EN adds the rsp_flags output.
module fadd_ctrl
  import fadd_ctrl_pkg::*;
#(
  parameter int unsigned FADD_LAT = FADD_LAT_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  input  logic             req_sub,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
`ifdef FADD_CTRL_EXC_EN
  output logic [2:0]       rsp_flags,
`endif
  output logic [31:0]      fa_x1,
  output logic [31:0]      fa_x2,
  input  logic [31:0]      fa_y
);

  localparam int unsigned FifoCntW = $clog2(DEPTH + 1);
  localparam int unsigned CredW    = FifoCntW + 1;
  localparam int unsigned InflW    = $clog2(FADD_LAT + 1);
`ifdef FADD_CTRL_EXC_EN
  localparam int unsigned FlagW    = 3;
`else
  localparam int unsigned FlagW    = 0;
`endif
  localparam int unsigned EntryW   = 32 + TAG_W + FlagW;

  logic                           rdy_en_q, rdy_en_d;
  logic [31:0]                    fa_x1_q, fa_x1_d;
  logic [31:0]                    fa_x2_q, fa_x2_d;
  logic [FADD_LAT-1:0]            vld_q, vld_d;
  logic [FADD_LAT-1:0][TAG_W-1:0] tag_q, tag_d;
`ifdef FADD_CTRL_EXC_EN
  logic [FADD_LAT-1:0]            spc_q, spc_d;
  exc_flags_t                     cap_flags;
`endif
  logic [InflW-1:0]               infl_q, infl_d;
  logic                           accept, capture;
  logic [EntryW-1:0]              push_data, head_data;
  logic [FifoCntW-1:0]            fifo_cnt;
  logic                           fifo_empty;
  logic [CredW-1:0]               credit_used;
  fp32_t                          x1_in, x2_in;

  // Credit check on registered counts; a same-cycle pop is deliberately not
  // credited, so every accepted op is guaranteed a FIFO slot at capture.
  always_comb begin
    credit_used = CredW'(infl_q) + CredW'(fifo_cnt);
    req_ready   = rdy_en_q && (credit_used < CredW'(DEPTH));
    accept      = req_valid && req_ready;
    capture     = vld_q[FADD_LAT-1];
  end

  // Next-state for operand registers, issue shift register and in-flight count.
  always_comb begin
    x1_in      = fp32_t'(req_x1);
    x2_in      = fp32_t'(req_x2);
    x2_in.sign = req_x2[31] ^ req_sub;
    rdy_en_d   = 1'b1;
    fa_x1_d    = fa_x1_q;
    fa_x2_d    = fa_x2_q;
    if (accept) begin
      fa_x1_d = x1_in;
      fa_x2_d = x2_in;
    end
    vld_d[0] = accept;
    tag_d[0] = req_tag;
    for (int i = 1; i < int'(FADD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
`ifdef FADD_CTRL_EXC_EN
    spc_d[0] = is_special(x1_in) || is_special(x2_in);
    for (int i = 1; i < int'(FADD_LAT); i++) begin
      spc_d[i] = spc_q[i-1];
    end
`endif
    case ({accept, capture})
      2'b10:   infl_d = infl_q + InflW'(1);
      2'b01:   infl_d = infl_q - InflW'(1);
      default: infl_d = infl_q;
    endcase
  end

  // State registers; rdy_en_q keeps req_ready low until the first edge after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en_q <= 1'b0;
      fa_x1_q  <= '0;
      fa_x2_q  <= '0;
      vld_q    <= '0;
      tag_q    <= '0;
`ifdef FADD_CTRL_EXC_EN
      spc_q    <= '0;
`endif
      infl_q   <= '0;
    end else begin
      rdy_en_q <= rdy_en_d;
      fa_x1_q  <= fa_x1_d;
      fa_x2_q  <= fa_x2_d;
      vld_q    <= vld_d;
      tag_q    <= tag_d;
`ifdef FADD_CTRL_EXC_EN
      spc_q    <= spc_d;
`endif
      infl_q   <= infl_d;
    end
  end

  // Assemble the FIFO entry from the fadd result and the tag leaving the pipe.
  always_comb begin
`ifdef FADD_CTRL_EXC_EN
    cap_flags = exc_flags(fp32_t'(fa_y), spc_q[FADD_LAT-1]);
    push_data = {fa_y, tag_q[FADD_LAT-1], cap_flags};
`else
    push_data = {fa_y, tag_q[FADD_LAT-1]};
`endif
  end

  fadd_ctrl_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (capture),
    .wdata (push_data),
    .pop   (rsp_ready),
    .rdata (head_data),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign fa_x1     = fa_x1_q;
  assign fa_x2     = fa_x2_q;
  assign rsp_valid = !fifo_empty;
  assign rsp_y     = head_data[EntryW-1 -: 32];
  assign rsp_tag   = head_data[FlagW +: TAG_W];
`ifdef FADD_CTRL_EXC_EN
  assign rsp_flags = head_data[2:0];
`endif

endmodule

// File: tb/tb_fadd_ctrl.sv
// Bench for fadd_ctrl: models the external fadd pipeline, keeps an in-order
// scoreboard of expected responses and runs directed plus random traffic.
module tb_fadd_ctrl;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid, req_ready, req_sub;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      req_x1, req_x2, rsp_y, fa_x1, fa_x2, fa_y;
  logic [TAG_W-1:0] req_tag, rsp_tag;
`ifdef FADD_CTRL_EXC_EN
  logic [2:0]       rsp_flags;
`endif

  always #5 clk = ~clk;

  fadd_ctrl #(
    .FADD_LAT (LAT),
    .DEPTH    (DEPTH),
    .TAG_W    (TAG_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_sub   (req_sub),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_tag   (rsp_tag),
`ifdef FADD_CTRL_EXC_EN
    .rsp_flags (rsp_flags),
`endif
    .fa_x1     (fa_x1),
    .fa_x2     (fa_x2),
    .fa_y      (fa_y)
  );

  // fp32 <-> double conversion (denormals flushed, result truncated).
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00)      d = {f[31], 63'b0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'b0};
    else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, (d[51:0] != 0) ? 23'h400000 : 23'h0};
    if (e >= 255) return {d[63], 8'hFF, 23'h0};
    if (e <= 0) return {d[63], 31'b0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  // External fadd: LAT-1 register stages after the operand registers.
  logic [31:0] fy_pipe [LAT-1];
  always @(posedge clk) begin
    fy_pipe[0] <= fp_add(fa_x1, fa_x2);
    for (int i = 1; i < int'(LAT) - 1; i++) fy_pipe[i] <= fy_pipe[i-1];
  end
  assign fa_y = fy_pipe[LAT-2];

  int n_pass = 0, n_total = 0, n_fail = 0;
  int n_acc = 0, n_rsp = 0, n_hs = 0, cyc = 0;
  logic [31:0]      exp_y   [$];
  logic [TAG_W-1:0] exp_tag [$];
  logic [2:0]       exp_fl  [$];
  int               rsp_cycs[$];
  logic             held = 1'b0;
  logic [31:0]      held_y;
  logic [TAG_W-1:0] held_tag;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_fp();
    if ($urandom_range(0, 15) == 0) return $urandom();
    return {1'($urandom()), 8'($urandom_range(100, 150)), 23'($urandom())};
  endfunction

  task automatic set_req(input logic [TAG_W-1:0] tag);
    req_x1  = rnd_fp();
    req_x2  = rnd_fp();
    req_sub = 1'($urandom());
    req_tag = tag;
  endtask

  // One clock: observe handshakes at the negedge, then return 1ns after the posedge.
  task automatic cycle();
    logic [31:0]      ey, b;
    logic [TAG_W-1:0] et;
    logic [2:0]       ef;
    @(negedge clk);
    if (held) begin
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_y", rsp_y, held_y);
      check("hold_tag", 32'(rsp_tag), 32'(held_tag));
    end
    held     = rsp_valid && !rsp_ready;
    held_y   = rsp_y;
    held_tag = rsp_tag;
    if (req_valid && req_ready) begin
      b  = req_sub ? {~req_x2[31], req_x2[30:0]} : req_x2;
      ey = fp_add(req_x1, b);
      exp_y.push_back(ey);
      exp_tag.push_back(req_tag);
      exp_fl.push_back({(req_x1[30:23] == 8'hFF) || (req_x2[30:23] == 8'hFF),
                        ey[30:0] == 31'h0, ey[30:23] == 8'hFF});
      n_acc++;
    end
    if (rsp_valid && rsp_ready) begin
      n_hs++;
      check("rsp_has_ref", 32'(exp_y.size() != 0), 1);
      if (exp_y.size() != 0) begin
        ey = exp_y.pop_front();
        et = exp_tag.pop_front();
        ef = exp_fl.pop_front();
        check("rsp_y", rsp_y, ey);
        check("rsp_tag", 32'(rsp_tag), 32'(et));
`ifdef FADD_CTRL_EXC_EN
        check("rsp_flags", 32'(rsp_flags), 32'(ef));
`endif
        n_rsp++;
        rsp_cycs.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (exp_y.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    check("drain_empty", 32'(exp_y.size()), 0);
  endtask

  // Issue one op and wait (bounded) until its response is presented.
  task automatic issue_wait(input logic [31:0] x1, input logic [31:0] x2, input logic sub,
                            input logic [TAG_W-1:0] tag, output int lat);
    req_x1 = x1; req_x2 = x2; req_sub = sub; req_tag = tag;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    check("issue_ready", 32'(req_ready), 1);
    cycle();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      cycle();
      lat++;
    end
  endtask

  initial begin
    int lat, a0, r0, h0, t, prev;
    rstn = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_x1 = '0; req_x2 = '0; req_sub = 1'b0; req_tag = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_fa_x1", fa_x1, 0);
    check("rst_fa_x2", fa_x2, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_rsp_tag", 32'(rsp_tag), 0);
    rstn = 1'b1;
    check("ready_before_edge", 32'(req_ready), 0);
    cycle();
    check("ready_after_release", 32'(req_ready), 1);

    // Add: accept is cycle 0, rsp_valid is high in cycle LAT+1, i.e. after edge E0+LAT.
    issue_wait(32'h3F800000, 32'h40000000, 1'b0, 5'd3, lat);
    check("add_latency", 32'(lat), LAT);
    check("add_y", rsp_y, 32'h40400000);
    check("add_tag", 32'(rsp_tag), 3);
    cycle();

    // Sub: operand 2 goes out sign-flipped and holds while idle.
    req_x1 = 32'h40400000; req_x2 = 32'h3F800000; req_sub = 1'b1; req_tag = 5'd7;
    req_valid = 1'b1;
    cycle();
    req_valid = 1'b0;
    check("sub_fa_x1", fa_x1, 32'h40400000);
    check("sub_fa_x2", fa_x2, 32'hBF800000);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check("sub_latency", 32'(lat), LAT);
    check("fa_x2_hold", fa_x2, 32'hBF800000);
    check("sub_y", rsp_y, 32'h40000000);
    check("sub_tag", 32'(rsp_tag), 7);
    drain(10);

    // Backpressure: only DEPTH accepts while the consumer stalls.
    rsp_ready = 1'b0; req_valid = 1'b1; t = 0; a0 = n_acc; r0 = n_rsp;
    set_req(5'(t));
    repeat (12) begin
      prev = n_acc;
      cycle();
      if (n_acc != prev) begin t++; set_req(5'(t)); end
    end
    check("bp_accepts", 32'(n_acc - a0), DEPTH);
    check("bp_ready_low", 32'(req_ready), 0);
    rsp_ready = 1'b1;
    lat = 0;
    while (t < 8 && lat < 60) begin
      prev = n_acc;
      cycle();
      lat++;
      if (n_acc != prev) begin
        t++;
        set_req(5'(t));
        if (t == 8) req_valid = 1'b0;
      end
    end
    drain(30);
    check("bp_returned", 32'(n_rsp - r0), 8);

    // Streaming: 16 back-to-back ops, responses on consecutive cycles.
    rsp_cycs.delete();
    r0 = n_rsp;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_req(5'(i + 8));
      req_valid = 1'b1;
      check("stream_ready", 32'(req_ready), 1);
      cycle();
    end
    drain(20);
    check("stream_count", 32'(n_rsp - r0), 16);
    if (rsp_cycs.size() == 16) check("stream_consec", 32'(rsp_cycs[15] - rsp_cycs[0]), 15);

    // Reset with two ops in flight and two in the FIFO.
    rsp_ready = 1'b0; a0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      set_req(5'(i));
      req_valid = 1'b1;
      cycle();
    end
    req_valid = 1'b0;
    check("mid_accepts", 32'(n_acc - a0), 4);
    check("mid_valid_before", 32'(rsp_valid), 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    check("mid_rst_rsp_y", rsp_y, 0);
    exp_y.delete(); exp_tag.delete(); exp_fl.delete();
    held = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    rsp_ready = 1'b1; h0 = n_hs;
    repeat (8) cycle();
    check("post_rst_no_rsp", 32'(n_hs - h0), 0);
    check("post_rst_ready", 32'(req_ready), 1);

`ifdef FADD_CTRL_EXC_EN
    issue_wait(32'h7F000000, 32'h7F000000, 1'b0, 5'd1, lat);
    check("exc_ovf", 32'(rsp_flags[0]), 1);
    cycle();
    issue_wait(32'h3F800000, 32'h3F800000, 1'b1, 5'd2, lat);
    check("exc_zero", 32'(rsp_flags[1]), 1);
    cycle();
`endif

    // Random traffic with random backpressure.
    a0 = n_acc; r0 = n_rsp;
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom());
      rsp_ready = ($urandom_range(0, 3) != 0);
      set_req(5'($urandom()));
      cycle();
    end
    drain(40);
    check("rand_all_returned", 32'(n_rsp - r0), 32'(n_acc - a0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fadd_ctrl.md
Name: fadd_ctrl

Overview:
- Requester-side controller for the pipelined fadd datapath, which has no handshake and a fixed latency.
- Accepts add/sub requests over valid/ready, drives fadd operands, and tracks in-flight ops with a valid/tag shift register.
- Captures results into a response FIFO and returns them in order over valid/ready with backpressure.
- Sits between the core's FP issue logic and the fadd instance.

Parameters:
- FADD_LAT, 2: fadd cycles from operand-register update to a valid fa_y.
- DEPTH, 4: response FIFO entries; must be >= FADD_LAT+1.
- TAG_W, 5: request tag width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_x1  in  32  operand 1 (IEEE single).
- req_x2  in  32  operand 2.
- req_sub  in  1  1 = x1 - x2.
- req_tag  in  TAG_W  returned unchanged with the result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_y  out  32  result.
- rsp_tag  out  TAG_W  tag of the result.
- fa_x1  out  32  to fadd x1.
- fa_x2  out  32  to fadd x2.
- fa_y  in  32  from fadd y.

Behaviour:
- Reset (async on rstn low, released synchronously to clk):
  - All outputs 0 (req_ready, rsp_valid, fa_x1, fa_x2, rsp_y, rsp_tag).
  - In-flight pipe and FIFO cleared.
  - req_ready is high from the first clk edge after release.
  - Reset mid-operation discards all in-flight ops and FIFO contents; no stale rsp_valid after release.
- Accept: req_valid & req_ready at edge E0.
  - fa_x1 <= req_x1.
  - fa_x2 <= {req_x2[31]^req_sub, req_x2[30:0]}.
  - An issue bit and tag enter stage 0 of a FADD_LAT-stage valid/tag shift register.
  - fa_x1/fa_x2 hold their value when no request is accepted.
- Capture: when the shift register's last stage is valid at edge E0+FADD_LAT, {fa_y, tag} is pushed into the FIFO.
- Latency: rsp_valid rises exactly FADD_LAT+1 cycles after E0 when the FIFO is empty. No bypass path.
- Credit: req_ready = (inflight_cnt + fifo_cnt) < DEPTH, computed from registered counters.
  - The count ignores a same-cycle pop (conservative). The FIFO therefore never overflows and captures are never dropped.
- inflight_cnt:
  - +1 on accept, -1 on capture.
  - Simultaneous accept and capture leaves it unchanged.
  - Range 0..FADD_LAT.
- FIFO:
  - Circular, log2(DEPTH)-bit pointers wrapping at DEPTH.
  - Simultaneous push and pop when full is legal (pop frees an entry first). When empty, push lands and rsp_valid rises next cycle.
  - rsp_y/rsp_tag come from the head entry and are stable while rsp_valid & !rsp_ready.
- Ordering: strictly in order; throughput of 1 op/cycle while the consumer drains.
- Back-to-back accepts every cycle are supported.

Optional Feature:
- Macro: FADD_CTRL_EXC_EN.
- Defined: adds output port rsp_flags (3 bits), stored in the FIFO alongside the result and computed at capture:
  - [0] overflow: fa_y[30:23]==8'hFF.
  - [1] zero: fa_y[30:0]==0.
  - [2] input special: either issued operand had exponent 8'hFF. Carried through the shift register.
- Undefined: port, FIFO field and shift-register bit are absent. Behaviour is otherwise identical.

Decomposition:
- Package fadd_ctrl_pkg holds:
  - the fp32 typedef (sign/exp/mant struct);
  - EXP_MAX = 8'hFF;
  - the flag struct typedef;
  - the default FADD_LAT/DEPTH constants.
- Sub-module fadd_ctrl_fifo: parameterised DEPTH x width synchronous FIFO with count output, async active-low reset.
- The fadd instance sits outside this block, at the parent level.

Test Plan:
- Add: x1=0x3F800000, x2=0x40000000, sub=0, tag=3 -> rsp_y=0x40400000, rsp_tag=3, rsp_valid exactly FADD_LAT+1 cycles after accept.
- Sub: x1=0x40400000, x2=0x3F800000, sub=1 -> fa_x2=0xBF800000; rsp_y=0x40000000.
- Backpressure: rsp_ready=0, req_valid=1 every cycle with tags 0..7 -> exactly DEPTH=4 accepts, req_ready low thereafter. Then rsp_ready=1 -> tags 0..7 returned in order, none lost or duplicated.
- Streaming: 16 back-to-back requests, rsp_ready=1 -> 16 responses on consecutive cycles, in order.
- Reset mid-flight: assert rstn=0 with 2 ops in flight and 2 in the FIFO -> rsp_valid=0 immediately. After release no responses appear and req_ready=1.
- With FADD_CTRL_EXC_EN: 0x7F000000 + 0x7F000000 yielding exp 0xFF -> rsp_flags[0]=1; 0x3F800000 - 0x3F800000 -> rsp_flags[1]=1.
